fp_to_fixed: RTL and testbench
==============================

Name: fp_to_fixed

Overview:
- Pipelined converter from IEEE-754 single precision to signed two's-complement fixed point (Q format, FRAC_BITS fraction bits).
- It is the decode-side counterpart of the floating-point adder. It takes sum_out-style floats back into the fixed-point datapath.
- It uses the same start-gated pipeline style: every stage advances only on cycles where start is high.
- done marks when the output is valid.

Parameters:
- OUT_W, 32: fixed-point output width (incl. sign), legal 8..48.
- FRAC_BITS, 16: fraction bits of output, legal 0..OUT_W-2.
- LATENCY, 4: enabled cycles from sample to output. Fixed; not user-overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  global pipeline enable. High = sample fp_in and advance all stages; low = freeze everything.
- fp_in  input  32  IEEE-754 single {sign, exp[7:0], frac[22:0]}.
- fixed_out  output  OUT_W  signed result, registered.
- overflow  output  1  result saturated: out of range or ±Inf.
- invalid  output  1  input was NaN.
- done  output  1  pipeline full; fixed_out corresponds to a sampled input.

Behaviour:
- Interface: one clock clk; reset rst_n is synchronous, active-low.
- Reset (rst_n low at a clk edge):
  - fixed_out=0, overflow=0, invalid=0, done=0.
  - All stage registers = 0. The fill counter = 0.
  - Reset mid-stream discards all in-flight data.
- Enable: with start low, every register holds, including outputs and done. No stage advances.
- Latency: fp_in sampled at edge k (start high) appears on fixed_out/overflow/invalid after the 4th enabled edge counting edge k.
- done:
  - A 3-bit fill counter increments on each enabled edge and saturates at LATENCY.
  - done is a register, set once the counter reaches LATENCY, and stays high until reset.
  - start low holds done unchanged.
- S0 decode, register:
  - sign; exp; mant25 = {2'b01, frac}.
  - is_zero = (exp==0): denormals flush to zero.
  - is_special = (exp==255).
  - is_nan = is_special && frac!=0.
- S1 shift amount:
  - sh = exp - 127 - 23 + FRAC_BITS, signed 10-bit.
  - Early overflow flag ovf_e = (exp-127 + FRAC_BITS >= OUT_W-1).
- S2 magnitude:
  - If sh>=0: mag = mant25 << sh. If sh<0: mag = mant25 >> -sh.
  - Shifts of 25 or more give mag=0.
  - Internal magnitude width is OUT_W+1; no silent wrap.
  - Truncation is toward zero (bits shifted out are dropped).
  - ovf = ovf_e OR mag > 2^(OUT_W-1)-1.
  - Exception: a negative input with mag == 2^(OUT_W-1) exactly is not overflow.
- S3 output, priority order:
  - is_nan: fixed_out=0, invalid=1, overflow=0.
  - is_special (Inf) or ovf: saturate. Positive gives 2^(OUT_W-1)-1; negative gives -2^(OUT_W-1). overflow=1.
  - is_zero: 0, flags 0. -0.0 also gives 0.
  - Otherwise: sign ? -mag : mag, flags 0.
  - A result of magnitude 0 after truncation always outputs 0, never negative zero.
- Back-to-back: a new input is accepted on every enabled cycle; throughput is 1 per enabled cycle.
- Flags are per-sample and aligned with fixed_out. They are not sticky.

Optional Feature:
- Macro: FP2FIX_ROUND_EN.
- Defined: in S2, a right shift rounds to nearest, ties away from zero.
  - Add the last shifted-out bit to mag. For sh<=-26 this bit is 0.
  - The overflow check is applied after rounding.
- Not defined: truncation toward zero. No round logic is synthesized; latency is unchanged either way.

Test Plan:
- Reset then 4 enabled cycles with fp_in=0x3F800000 (1.0) -> fixed_out=0x00010000, done rises on the 4th edge, flags 0. fp_in=0xC0200000 (-2.5) on the next cycle -> 0xFFFD8000 one cycle later.
- fp_in=0x37800000 (2^-16) -> 0x00000001. fp_in=0x37000000 (2^-17) -> 0x00000000 without macro, 0x00000001 with FP2FIX_ROUND_EN. fp_in=0x80000000 (-0.0) -> 0.
- fp_in=0x471C4000 (40000.0) -> 0x7FFFFFFF, overflow=1. fp_in=0xC7000000 (-32768.0) -> 0x80000000, overflow=0. fp_in=0xC7000100 -> 0x80000000, overflow=1.
- fp_in=0x7F800000 (+Inf) -> 0x7FFFFFFF, overflow=1. fp_in=0xFF800000 -> 0x80000000, overflow=1. fp_in=0x7FC00000 (NaN) -> 0, invalid=1.
- Stream 1.0, 2.0, 3.0 with start dropped low 3 cycles after the 2nd sample -> outputs and done frozen during the gap. The sequence 0x00010000, 0x00020000, 0x00030000 completes with no loss or duplication.
- Assert rst_n low for one edge mid-stream -> all outputs and done 0 next cycle. The first valid output needs 4 new enabled cycles.

Source files
------------

// File: rtl/fp_to_fixed.sv
// rtl/fp_to_fixed.sv - IEEE-754 single to signed fixed-point converter, 4-stage start-gated pipeline
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   start     in   pipeline enable: high samples fp_in and advances every stage, low freezes all state
//   fp_in     in   [31:0] {sign, exp[7:0], frac[22:0]}
//   fixed_out out  [OUT_W-1:0] signed Q result with FRAC_BITS fraction bits
//   overflow  out  result saturated (out of range or infinity)
//   invalid   out  input was NaN
//   done      out  pipeline full; fixed_out belongs to a sampled input
//
// Optional macro FP2FIX_ROUND_EN: right shifts round to nearest, ties away
// from zero. Without it, magnitudes truncate toward zero.

module fp_to_fixed #(
  parameter int OUT_W     = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      fp_in,
  output logic [OUT_W-1:0] fixed_out,
  output logic             overflow,
  output logic             invalid,
  output logic             done
);

  localparam int LATENCY = 4;
  // Wide enough that mant25 shifted left into the overflow region never wraps.
  localparam int MW = OUT_W + 26;

  localparam logic signed [11:0] FB12   = 12'(FRAC_BITS);
  localparam logic signed [11:0] OMAX12 = 12'(OUT_W - 1);
  localparam logic [MW-1:0]      MINMAG = MW'(1) << (OUT_W - 1);
  localparam logic [MW-1:0]      MAXPOS = MINMAG - MW'(1);

  // S0 decode
  logic        s0_sign, s0_zero, s0_special, s0_nan;
  logic [7:0]  s0_exp;
  logic [24:0] s0_mant;

  // S1 shift amount
  logic              s1_sign, s1_zero, s1_special, s1_nan, s1_ovf_e;
  logic [24:0]       s1_mant;
  logic signed [9:0] s1_sh;

  // S2 magnitude
  logic           s2_sign, s2_zero, s2_special, s2_nan, s2_ovf;
  logic [OUT_W:0] s2_mag;

  logic [2:0] fill_cnt;

  // S1 combinational
  logic signed [11:0] e_unb, sh_full;
  logic               ovf_e_c;

  always_comb begin
    e_unb   = $signed({4'b0000, s0_exp}) - 12'sd127;
    sh_full = e_unb - 12'sd23 + FB12;
    ovf_e_c = (e_unb + FB12) >= OMAX12;
  end

  // S2 combinational
  logic [MW-1:0] mant_w, big;
  logic [9:0]    lsh, rsh;
  logic          ovf_c;
`ifdef FP2FIX_ROUND_EN
  logic [MW-1:0] rtmp;
  logic          rbit;
`endif

  always_comb begin
    mant_w = {{(MW-25){1'b0}}, s1_mant};
    lsh    = s1_sh;
    rsh    = -s1_sh;
    // Shifts past the vector width yield zero, covering the >=25 right-shift case.
    if (!s1_sh[9]) big = mant_w << lsh;
    else           big = mant_w >> rsh;
`ifdef FP2FIX_ROUND_EN
    // Last shifted-out bit is mant25[rsh-1]; zero once rsh-1 runs past the mantissa.
    rtmp = '0;
    rbit = 1'b0;
    if (s1_sh[9]) begin
      rtmp = mant_w >> (rsh - 10'd1);
      rbit = |(rtmp & MW'(1));
    end
    big = big + MW'(rbit);
`endif
    // Exactly -2^(OUT_W-1) is representable even though ovf_e fires for it.
    ovf_c = (s1_ovf_e || (big > MAXPOS)) && !(s1_sign && (big == MINMAG));
  end

  // S3 combinational
  logic [OUT_W-1:0] mag_n, res_c;
  logic             ovf_out_c, inv_out_c;

  always_comb begin
    mag_n     = s2_mag[OUT_W-1:0];
    res_c     = s2_sign ? (~mag_n + 1'b1) : mag_n;
    ovf_out_c = 1'b0;
    inv_out_c = 1'b0;
    if (s2_nan) begin
      res_c     = '0;
      inv_out_c = 1'b1;
    end else if (s2_special || s2_ovf) begin
      res_c     = s2_sign ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      ovf_out_c = 1'b1;
    end else if (s2_zero) begin
      res_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_sign    <= 1'b0;
      s0_zero    <= 1'b0;
      s0_special <= 1'b0;
      s0_nan     <= 1'b0;
      s0_exp     <= '0;
      s0_mant    <= '0;
      s1_sign    <= 1'b0;
      s1_zero    <= 1'b0;
      s1_special <= 1'b0;
      s1_nan     <= 1'b0;
      s1_ovf_e   <= 1'b0;
      s1_mant    <= '0;
      s1_sh      <= '0;
      s2_sign    <= 1'b0;
      s2_zero    <= 1'b0;
      s2_special <= 1'b0;
      s2_nan     <= 1'b0;
      s2_ovf     <= 1'b0;
      s2_mag     <= '0;
      fixed_out  <= '0;
      overflow   <= 1'b0;
      invalid    <= 1'b0;
      done       <= 1'b0;
      fill_cnt   <= '0;
    end else if (start) begin
      s0_sign    <= fp_in[31];
      s0_exp     <= fp_in[30:23];
      s0_mant    <= {2'b01, fp_in[22:0]};
      s0_zero    <= (fp_in[30:23] == 8'd0);
      s0_special <= (fp_in[30:23] == 8'hFF);
      s0_nan     <= (fp_in[30:23] == 8'hFF) && (fp_in[22:0] != 23'd0);

      s1_sign    <= s0_sign;
      s1_zero    <= s0_zero;
      s1_special <= s0_special;
      s1_nan     <= s0_nan;
      s1_mant    <= s0_mant;
      s1_sh      <= sh_full[9:0];
      s1_ovf_e   <= ovf_e_c;

      s2_sign    <= s1_sign;
      s2_zero    <= s1_zero;
      s2_special <= s1_special;
      s2_nan     <= s1_nan;
      s2_ovf     <= ovf_c;
      s2_mag     <= big[OUT_W:0];

      fixed_out  <= res_c;
      overflow   <= ovf_out_c;
      invalid    <= inv_out_c;

      if (fill_cnt != 3'(LATENCY)) fill_cnt <= fill_cnt + 3'd1;
      // Rises on the same edge the counter reaches LATENCY.
      if (fill_cnt >= 3'(LATENCY - 1)) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_to_fixed.sv
// tb/tb_fp_to_fixed.sv - directed self-checking bench for fp_to_fixed

module tb_fp_to_fixed;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] fp_in;
  logic [31:0] fixed_out;
  logic        overflow;
  logic        invalid;
  logic        done;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef FP2FIX_ROUND_EN
  localparam logic [31:0] EXP_HALF  = 32'h00000001;
  localparam logic [31:0] EXP_NHALF = 32'hFFFFFFFF;
  localparam logic [31:0] EXP_1P5   = 32'h00000002;
`else
  localparam logic [31:0] EXP_HALF  = 32'h00000000;
  localparam logic [31:0] EXP_NHALF = 32'h00000000;
  localparam logic [31:0] EXP_1P5   = 32'h00000001;
`endif

  fp_to_fixed #(.OUT_W(32), .FRAC_BITS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .fp_in     (fp_in),
    .fixed_out (fixed_out),
    .overflow  (overflow),
    .invalid   (invalid),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    fp_in = 32'h0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    start = 1'b1;
    fp_in = 32'h3F800000;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    start = 1'b0;
    n_cmp++;
    if ({fixed_out, overflow, invalid, done} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_state: got out=%h ovf=%b inv=%b done=%b, want all 0", fixed_out, overflow, invalid, done);
    end
  endtask

  task automatic test_latency();
    do_reset();
    start = 1'b1;
    fp_in = 32'h3F800000;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_cmp++;
      if (i < 4 && (done !== 1'b0 || fixed_out !== 32'h0)) begin
        n_fail++;
        $display("FAIL latency_fill edge %0d: got out=%h done=%b, want 0/0", i, fixed_out, done);
      end else if (i == 4 && {fixed_out, overflow, invalid, done} !== {32'h00010000, 3'b001}) begin
        n_fail++;
        $display("FAIL latency_one: got out=%h ovf=%b inv=%b done=%b, want 00010000/0/0/1", fixed_out, overflow, invalid, done);
      end
    end
    fp_in = 32'hC0200000;
    for (int i = 1; i <= 4; i++) begin
      tick();
      fp_in = 32'h0;
    end
    n_cmp++;
    if ({fixed_out, overflow, invalid} !== {32'hFFFD8000, 2'b00}) begin
      n_fail++;
      $display("FAIL neg_2p5: got out=%h ovf=%b inv=%b, want fffd8000/0/0", fixed_out, overflow, invalid);
    end
  endtask

  task automatic test_small();
    logic [31:0] vin  [8] = '{32'h37800000, 32'h37000000, 32'h80000000, 32'h3F000000,
                              32'h00400000, 32'hB7800000, 32'hB7000000, 32'h37C00000};
    logic [31:0] vexp [8] = '{32'h00000001, EXP_HALF, 32'h0, 32'h00008000,
                              32'h0, 32'hFFFFFFFF, EXP_NHALF, EXP_1P5};
    start = 1'b1;
    for (int i = 0; i < 11; i++) begin
      fp_in = (i < 8) ? vin[i] : 32'h0;
      tick();
      if (i >= 3) begin
        n_cmp++;
        if ({fixed_out, overflow, invalid, done} !== {vexp[i-3], 3'b001}) begin
          n_fail++;
          $display("FAIL small[%0d] in=%h: got out=%h ovf=%b inv=%b done=%b, want %h/0/0/1",
                   i-3, vin[i-3], fixed_out, overflow, invalid, done, vexp[i-3]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] vin  [5] = '{32'h471C4000, 32'hC7000000, 32'hC7000100, 32'h46FFFFFE, 32'h47000000};
    logic [31:0] vexp [5] = '{32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h7FFFFF00, 32'h7FFFFFFF};
    logic        vovf [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fp_in = (i < 5) ? vin[i] : 32'h0;
      tick();
      if (i >= 3) begin
        n_cmp++;
        if ({fixed_out, overflow, invalid} !== {vexp[i-3], vovf[i-3], 1'b0}) begin
          n_fail++;
          $display("FAIL sat[%0d] in=%h: got out=%h ovf=%b inv=%b, want %h/%b/0",
                   i-3, vin[i-3], fixed_out, overflow, invalid, vexp[i-3], vovf[i-3]);
        end
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] vin  [5] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'hFFFFFFFF, 32'h3F800000};
    logic [31:0] vexp [5] = '{32'h7FFFFFFF, 32'h80000000, 32'h0, 32'h0, 32'h00010000};
    logic [1:0]  vflg [5] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00};
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fp_in = (i < 5) ? vin[i] : 32'h0;
      tick();
      if (i >= 3) begin
        n_cmp++;
        if ({fixed_out, overflow, invalid} !== {vexp[i-3], vflg[i-3]}) begin
          n_fail++;
          $display("FAIL special[%0d] in=%h: got out=%h ovf=%b inv=%b, want %h/%b",
                   i-3, vin[i-3], fixed_out, overflow, invalid, vexp[i-3], vflg[i-3]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vin  [3] = '{32'h3F800000, 32'h40000000, 32'h40400000};
    logic [31:0] vexp [3] = '{32'h00010000, 32'h00020000, 32'h00030000};
    do_reset();
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fp_in = vin[i];
      tick();
    end
    // Gap: an unsampled NaN on fp_in must not enter the pipeline.
    start = 1'b0;
    fp_in = 32'h7FC00000;
    for (int g = 0; g < 3; g++) begin
      tick();
      n_cmp++;
      if ({fixed_out, overflow, invalid, done} !== 35'h0) begin
        n_fail++;
        $display("FAIL gap_freeze[%0d]: got out=%h ovf=%b inv=%b done=%b, want all 0", g, fixed_out, overflow, invalid, done);
      end
    end
    start = 1'b1;
    fp_in = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({fixed_out, overflow, invalid, done} !== {vexp[i], 3'b001}) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got out=%h ovf=%b inv=%b done=%b, want %h/0/0/1", i, fixed_out, overflow, invalid, done, vexp[i]);
      end
    end
    // Frozen with done high.
    start = 1'b0;
    fp_in = 32'h40800000;
    tick();
    tick();
    n_cmp++;
    if ({fixed_out, done} !== {32'h00030000, 1'b1}) begin
      n_fail++;
      $display("FAIL hold_done: got out=%h done=%b, want 00030000/1", fixed_out, done);
    end
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    fp_in = 32'h3F800000;
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if ({fixed_out, done} !== {32'h00010000, 1'b1}) begin
      n_fail++;
      $display("FAIL pre_reset: got out=%h done=%b, want 00010000/1", fixed_out, done);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if ({fixed_out, overflow, invalid, done} !== 35'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got out=%h ovf=%b inv=%b done=%b, want all 0", fixed_out, overflow, invalid, done);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_cmp++;
      if (i < 4 && {fixed_out, done} !== 33'h0) begin
        n_fail++;
        $display("FAIL refill edge %0d: got out=%h done=%b, want 0/0", i, fixed_out, done);
      end else if (i == 4 && {fixed_out, done} !== {32'h00010000, 1'b1}) begin
        n_fail++;
        $display("FAIL refill_valid: got out=%h done=%b, want 00010000/1", fixed_out, done);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fp_in = 32'h0;
    test_reset();
    test_latency();
    test_small();
    test_saturation();
    test_special();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
